// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: state and cause encodings,
// PC-source mux select codes (also used by the main control unit), default sizing.
package exc_sequencer_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned CAUSE_W      = 2;
    localparam int unsigned PC_SEL_W     = 3;
    localparam int unsigned VEC_BASE_DEF = 253;
    localparam int unsigned MEM_LAT_DEF  = 2;

    localparam logic [PC_SEL_W-1:0] PC_SEL_NORM = 3'd0;
    localparam logic [PC_SEL_W-1:0] PC_SEL_VEC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_RD   = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_OPCODE = 2'd0,
        CAUSE_OVF    = 2'd1,
        CAUSE_DIV0   = 2'd2
    } cause_t;

    // Fixed priority: invalid opcode, then overflow, then divide by zero.
    function automatic cause_t encode_cause(input logic opcode, input logic ovf, input logic div0);
        cause_t c;
        c = CAUSE_DIV0;
        if (opcode) begin
            c = CAUSE_OPCODE;
        end else if (ovf) begin
            c = CAUSE_OVF;
        end else if (div0) begin
            c = CAUSE_DIV0;
        end
        return c;
    endfunction

endpackage

// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer: saves EPC, fetches the handler vector byte and
// loads it into PC while holding the main control FSM frozen via busy.
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter int unsigned          VEC_BASE = VEC_BASE_DEF,
    parameter int unsigned          MEM_LAT  = MEM_LAT_DEF,
    parameter logic [PC_SEL_W-1:0]  SEL_NORM = PC_SEL_NORM,
    parameter logic [PC_SEL_W-1:0]  SEL_VEC  = PC_SEL_VEC
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                exc_opcode,
    input  logic                exc_ovf,
    input  logic                exc_div0,
    output logic                busy,
    output logic                done,
    output logic [CAUSE_W-1:0]  cause,
    output logic                epc_write,
    output logic                exc_addr_sel,
    output logic [ADDR_W-1:0]   exc_addr,
    output logic                mem_rd,
    output logic [PC_SEL_W-1:0] pc_src_sel,
    output logic                pc_write,
    output logic                lost_exc
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    state_t             state_q, state_d;
    cause_t             cause_q, cause_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lost_q;
    logic               any_exc;
    logic               epc_write_dec;
    logic               pc_write_dec;

    assign any_exc = exc_opcode | exc_ovf | exc_div0;

    // State, latched cause, read-latency counter and sticky lost-exception flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_OPCODE;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_q | (any_exc & (state_q != ST_IDLE));
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        cnt_d         = cnt_q;
        busy          = 1'b1;
        done          = 1'b0;
        epc_write_dec = 1'b0;
        exc_addr_sel  = 1'b0;
        mem_rd        = 1'b0;
        pc_src_sel    = SEL_NORM;
        pc_write_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (any_exc) begin
                    cause_d = encode_cause(exc_opcode, exc_ovf, exc_div0);
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                epc_write_dec = 1'b1;
                cnt_d         = CNT_W'(MEM_LAT - 1);
                state_d       = ST_RD;
            end
            ST_RD: begin
                exc_addr_sel = 1'b1;
                mem_rd       = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                exc_addr_sel = 1'b1;
                pc_src_sel   = SEL_VEC;
                pc_write_dec = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A reset asserted mid-sequence suppresses write enables in that same cycle.
    assign epc_write = epc_write_dec & reset_n;
    assign pc_write  = pc_write_dec & reset_n;
    assign cause     = cause_q;
    assign exc_addr  = ADDR_W'(VEC_BASE) + ADDR_W'(cause_q);
    assign lost_exc  = lost_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: three builds (MEM_LAT 1, 2, 4) share stimulus and are
// checked every cycle against a sequence-position model plus hand-computed points.
module tb_exc_sequencer;

    logic clk;
    logic reset_n;
    logic exc_opcode, exc_ovf, exc_div0;

    logic        busy_v   [3];
    logic        done_v   [3];
    logic [1:0]  cause_v  [3];
    logic        epc_v    [3];
    logic        asel_v   [3];
    logic [31:0] addr_v   [3];
    logic        mrd_v    [3];
    logic [2:0]  psel_v   [3];
    logic        pcw_v    [3];
    logic        lost_v   [3];

    int errors = 0;
    int checks = 0;

    // Model: position within the sequence (0 idle, 1 = cycle after the exception edge).
    int         pos    [3];
    logic [1:0] mcause [3];
    logic       mlost  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exc_sequencer #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
        .exc_div0(exc_div0), .busy(busy_v[0]), .done(done_v[0]), .cause(cause_v[0]),
        .epc_write(epc_v[0]), .exc_addr_sel(asel_v[0]), .exc_addr(addr_v[0]),
        .mem_rd(mrd_v[0]), .pc_src_sel(psel_v[0]), .pc_write(pcw_v[0]), .lost_exc(lost_v[0]));

    exc_sequencer #(.MEM_LAT(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
        .exc_div0(exc_div0), .busy(busy_v[1]), .done(done_v[1]), .cause(cause_v[1]),
        .epc_write(epc_v[1]), .exc_addr_sel(asel_v[1]), .exc_addr(addr_v[1]),
        .mem_rd(mrd_v[1]), .pc_src_sel(psel_v[1]), .pc_write(pcw_v[1]), .lost_exc(lost_v[1]));

    exc_sequencer #(.MEM_LAT(4)) u_lat4 (
        .clk(clk), .reset_n(reset_n), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
        .exc_div0(exc_div0), .busy(busy_v[2]), .done(done_v[2]), .cause(cause_v[2]),
        .epc_write(epc_v[2]), .exc_addr_sel(asel_v[2]), .exc_addr(addr_v[2]),
        .mem_rd(mrd_v[2]), .pc_src_sel(psel_v[2]), .pc_write(pcw_v[2]), .lost_exc(lost_v[2]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance one clock edge and move the model by the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int L;
            logic any;
            L = lat_of(i);
            any = exc_opcode | exc_ovf | exc_div0;
            if (!reset_n) begin
                pos[i] = 0; mcause[i] = 2'd0; mlost[i] = 1'b0;
            end else if (pos[i] == 0) begin
                if (any) begin
                    pos[i] = 1;
                    if (exc_opcode)   mcause[i] = 2'd0;
                    else if (exc_ovf) mcause[i] = 2'd1;
                    else              mcause[i] = 2'd2;
                end
            end else begin
                if (any) mlost[i] = 1'b1;
                pos[i] = (pos[i] == L + 3) ? 0 : pos[i] + 1;
            end
        end
        #1;
    endtask

    // Mid-cycle comparison of every build against the model.
    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int L;
            logic [43:0] got, exp;
            L = lat_of(i);
            got = {busy_v[i], done_v[i], cause_v[i], epc_v[i], asel_v[i], mrd_v[i],
                   psel_v[i], pcw_v[i], lost_v[i], addr_v[i]};
            exp = {pos[i] != 0, pos[i] == L + 3, mcause[i],
                   (pos[i] == 1) && reset_n,
                   (pos[i] >= 2) && (pos[i] <= L + 2),
                   (pos[i] >= 2) && (pos[i] <= L + 1),
                   (pos[i] == L + 2) ? 3'd4 : 3'd0,
                   (pos[i] == L + 2) && reset_n,
                   mlost[i],
                   32'd253 + {30'd0, mcause[i]}};
            chk($sformatf("model_lat%0d", L), 64'(got), 64'(exp));
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pos[i] = 0; mcause[i] = 2'd0; mlost[i] = 1'b0;
        end
        reset_n = 1'b0; exc_opcode = 1'b0; exc_ovf = 1'b1; exc_div0 = 1'b0;

        // Reset held two cycles with an exception pending
        tick();
        sample();
        chk("rst_busy", 64'(busy_v[1]), 64'd0);
        chk("rst_pcsel", 64'(psel_v[1]), 64'd0);
        tick();
        sample();
        chk("rst_lost", 64'(lost_v[1]), 64'd0);
        chk("rst_epc", 64'(epc_v[1]), 64'd0);
        tick();
        reset_n = 1'b1; exc_ovf = 1'b0;
        run(3);

        // Single overflow pulse, edge k
        exc_ovf = 1'b1;
        sample(); tick();
        exc_ovf = 1'b0;
        sample();                                       // k+1
        chk("single_epc", 64'(epc_v[1]), 64'd1);
        tick(); sample();                               // k+2
        chk("single_rd_k2", 64'(mrd_v[1]), 64'd1);
        chk("single_addr", 64'(addr_v[1]), 64'd254);
        tick(); sample();                               // k+3
        chk("single_rd_k3", 64'(mrd_v[1]), 64'd1);
        chk("lat1_pcw_k3", 64'(pcw_v[0]), 64'd1);
        tick(); sample();                               // k+4
        chk("single_pcw", 64'(pcw_v[1]), 64'd1);
        chk("single_pcsel", 64'(psel_v[1]), 64'd4);
        chk("lat1_done_k4", 64'(done_v[0]), 64'd1);
        chk("lat4_rd_k4", 64'(mrd_v[2]), 64'd1);
        tick(); sample();                               // k+5
        chk("single_done", 64'(done_v[1]), 64'd1);
        chk("lat4_rd_k5", 64'(mrd_v[2]), 64'd1);
        tick(); sample();                               // k+6
        chk("lat4_pcw_k6", 64'(pcw_v[2]), 64'd1);
        chk("single_idle", 64'(busy_v[1]), 64'd0);
        tick(); sample();                               // k+7
        chk("lat4_done_k7", 64'(done_v[2]), 64'd1);
        tick();
        run(2);

        // Priority: all three together, then overflow with div0
        exc_opcode = 1'b1; exc_ovf = 1'b1; exc_div0 = 1'b1;
        sample(); tick();
        exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
        sample();
        chk("prio_all_cause", 64'(cause_v[1]), 64'd0);
        chk("prio_all_addr", 64'(addr_v[1]), 64'd253);
        tick();
        run(8);
        exc_ovf = 1'b1; exc_div0 = 1'b1;
        sample(); tick();
        exc_ovf = 1'b0; exc_div0 = 1'b0;
        sample();
        chk("prio_ovf_cause", 64'(cause_v[1]), 64'd1);
        tick();
        run(8);

        // Nested: opcode arrives during RD of a div0 sequence
        exc_div0 = 1'b1;
        sample(); tick();
        exc_div0 = 1'b0;
        sample(); tick();                               // now k+2 (RD)
        exc_opcode = 1'b1;
        sample(); tick();
        exc_opcode = 1'b0;
        sample();
        chk("nest_cause", 64'(cause_v[1]), 64'd2);
        chk("nest_addr", 64'(addr_v[1]), 64'd255);
        chk("nest_lost", 64'(lost_v[1]), 64'd1);
        tick();
        run(8);
        sample();
        chk("nest_lost_sticky", 64'(lost_v[1]), 64'd1);
        tick();

        // Abort: reset in the LOAD cycle of the MEM_LAT=2 build
        exc_ovf = 1'b1;
        sample(); tick();
        exc_ovf = 1'b0;
        run(3);                                         // now k+4 (LOAD)
        reset_n = 1'b0;
        sample();
        chk("abort_no_pcw", 64'(pcw_v[1]), 64'd0);
        tick();
        reset_n = 1'b1;
        sample();
        chk("abort_idle", 64'(busy_v[1]), 64'd0);
        chk("abort_lost_clr", 64'(lost_v[1]), 64'd0);
        tick();
        run(2);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset_n    = ($urandom_range(0, 99) != 0);
            exc_opcode = ($urandom_range(0, 15) == 0);
            exc_ovf    = ($urandom_range(0, 15) == 0);
            exc_div0   = ($urandom_range(0, 15) == 0);
            sample();
            tick();
        end
        reset_n = 1'b1; exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
